// File: rtl/aes_sbox_sched.sv
// aes_sbox_sched: round-robin scheduler that feeds shared bytes from NREQ requesters
// into a fixed-latency masked AES S-box. It tags each result with its requester index,
// buffers results in a FIFO and uses credits so that FIFO can never overflow.
// Build option: define SBOX_IDLE_ZERO_EN to drive zeros on the S-box inputs during
// idle cycles. When it is undefined, the inputs keep the last issued operands.
module aes_sbox_sched #(
  parameter int SHARES = 2,
  parameter int NREQ   = 4,
  parameter int LAT    = 5,
  parameter int RZW    = 8,
  parameter int RBW    = 40,
  parameter int FDEPTH = 8,
  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int DW    = 8 * SHARES
) (
  input  logic               ClkxCI,
  input  logic               RstxRI,
  input  logic [NREQ-1:0]    ReqValidxSI,
  output logic [NREQ-1:0]    ReqReadyxSO,
  input  logic [NREQ*DW-1:0] ReqDataxDI,
  input  logic               RndValidxSI,
  output logic               RndReadyxSO,
  input  logic [RZW-1:0]     RndZxDI,
  input  logic [RBW-1:0]     RndBxDI,
  output logic [DW-1:0]      SboxXxDO,
  output logic [RZW-1:0]     SboxZxDO,
  output logic [RBW-1:0]     SboxBxDO,
  input  logic [DW-1:0]      SboxQxDI,
  output logic               OutValidxSO,
  input  logic               OutReadyxSI,
  output logic [IW-1:0]      OutIdxDO,
  output logic [DW-1:0]      OutQxDO,
  input  logic               FlushxSI,
  output logic               FlushDonexSO
);
  localparam int CW = $clog2(FDEPTH + LAT + 2) + 1;
  localparam int FW = $clog2(FDEPTH + 1);
  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             done_d, flush_done_q;
  logic [IW-1:0]    ptr_q;
  logic             grant_vld;
  logic [IW-1:0]    grant_idx;
  logic             issue, pop, push, credit_ok;
  logic [CW-1:0]    inflight, used;
  logic             in_vld_q;
  logic [IW-1:0]    in_idx_q;
  logic [DW-1:0]    x_q;
  logic [RZW-1:0]   z_q;
  logic [RBW-1:0]   b_q;
  logic [LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [IW-1:0]    tag_idx_q [LAT];
  logic [IW-1:0]    tag_idx_d [LAT];
  logic [IW+DW-1:0] fifo_mem [FDEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [FW-1:0]    fifo_cnt_q;

  function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick: the first valid requester at or after the pointer.
  // The loop scans downwards, so the lowest offset is the last one written and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (ReqValidxSI[(int'(ptr_q) + k) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Operations in flight: the input register plus every tag stage.
  always_comb begin
    inflight = CW'(in_vld_q);
    for (int s = 0; s < LAT; s++) begin
      inflight = inflight + CW'(tag_vld_q[s]);
    end
  end

  assign pop       = OutValidxSO & OutReadyxSI;
  assign push      = tag_vld_q[LAT-1];
  assign used      = inflight + CW'(fifo_cnt_q);
  // A pop in this cycle frees a slot before the next issue can land.
  assign credit_ok = used < (CW'(FDEPTH) + CW'(pop));
  assign issue     = !RstxRI && (state_q == ST_RUN) && !FlushxSI && RndValidxSI
                     && grant_vld && credit_ok;

  // Drive the one-hot accept to the granted requester, but only for a real issue.
  always_comb begin
    ReqReadyxSO = '0;
    if (issue) ReqReadyxSO[grant_idx] = 1'b1;
  end
  assign RndReadyxSO = issue;

  // Register the issued operands that go to the S-box.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      in_vld_q <= 1'b0;
      in_idx_q <= '0;
      x_q      <= '0;
      z_q      <= '0;
      b_q      <= '0;
    end else begin
      in_vld_q <= issue;
      if (issue) begin
        in_idx_q <= grant_idx;
        x_q      <= ReqDataxDI[int'(grant_idx)*DW +: DW];
        z_q      <= RndZxDI;
        b_q      <= RndBxDI;
      end
`ifdef SBOX_IDLE_ZERO_EN
      else begin
        x_q <= '0;
        z_q <= '0;
        b_q <= '0;
      end
`endif
    end
  end

  assign SboxXxDO = x_q;
  assign SboxZxDO = z_q;
  assign SboxBxDO = b_q;

  // Tags travel alongside the S-box pipeline. Stage 0 is fed from the input register.
  for (genvar gi = 0; gi < LAT; gi++) begin : g_tag_src
    if (gi == 0) begin : g_first
      assign tag_vld_d[gi] = in_vld_q;
      assign tag_idx_d[gi] = in_idx_q;
    end else begin : g_next
      assign tag_vld_d[gi] = tag_vld_q[gi-1];
      assign tag_idx_d[gi] = tag_idx_q[gi-1];
    end
  end

  // Advance the tag pipeline. Reset clears the valid bits, so results returning late are dropped.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) tag_vld_q <= '0;
    else        tag_vld_q <= tag_vld_d;
    tag_idx_q <= tag_idx_d;
  end

  // Write a tagged S-box result into the FIFO storage.
  always_ff @(posedge ClkxCI) begin
    if (push) fifo_mem[wr_ptr_q] <= {tag_idx_q[LAT-1], SboxQxDI};
  end

  // Maintain the FIFO pointers and occupancy. Push and pop together leave the count unchanged.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= fifo_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= fifo_inc(rd_ptr_q);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + FW'(1);
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - FW'(1);
    end
  end

  assign OutValidxSO = (fifo_cnt_q != '0);
  assign OutIdxDO    = fifo_mem[rd_ptr_q][IW+DW-1:DW];
  assign OutQxDO     = fifo_mem[rd_ptr_q][DW-1:0];

  // Move the round-robin pointer past the requester that was just granted.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI)     ptr_q <= '0;
    else if (issue) ptr_q <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
  end

  // Flush sequencing: stop issuing, wait until nothing is in flight or buffered, then report done.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN:   if (FlushxSI) state_d = ST_DRAIN;
      ST_DRAIN: if (inflight == '0 && fifo_cnt_q == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                end
      ST_DONE:  if (!FlushxSI) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Register the FSM state and the single-cycle done pulse.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= done_d;
    end
  end

  assign FlushDonexSO = flush_done_q;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Testbench for aes_sbox_sched. It uses a transaction-level reference model:
// a queue of outstanding results with their due cycles, a round-robin pointer,
// and a credit limit. An ideal S-box model closes the loop.
module tb_aes_sbox_sched;
  localparam int SHARES = 2, NREQ = 4, LAT = 5, RZW = 8, RBW = 40, FDEPTH = 8;
  localparam int DW = 8 * SHARES;
  localparam int IW = 2;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic               rnd_valid, rnd_ready;
  logic [RZW-1:0]     rnd_z, sbox_z;
  logic [RBW-1:0]     rnd_b, sbox_b;
  logic [DW-1:0]      sbox_x, sbox_q, out_q;
  logic               out_valid, out_ready, flush, flush_done;
  logic [IW-1:0]      out_idx;

  aes_sbox_sched #(.SHARES(SHARES), .NREQ(NREQ), .LAT(LAT), .RZW(RZW), .RBW(RBW),
                   .FDEPTH(FDEPTH)) dut (
    .ClkxCI(clk), .RstxRI(rst),
    .ReqValidxSI(req_valid), .ReqReadyxSO(req_ready), .ReqDataxDI(req_data),
    .RndValidxSI(rnd_valid), .RndReadyxSO(rnd_ready), .RndZxDI(rnd_z), .RndBxDI(rnd_b),
    .SboxXxDO(sbox_x), .SboxZxDO(sbox_z), .SboxBxDO(sbox_b), .SboxQxDI(sbox_q),
    .OutValidxSO(out_valid), .OutReadyxSI(out_ready), .OutIdxDO(out_idx), .OutQxDO(out_q),
    .FlushxSI(flush), .FlushDonexSO(flush_done)
  );

  // GF(2^8) arithmetic with the AES polynomial
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // AES S-box: inverse (x^254) followed by the affine transform
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] xor_shares(input logic [DW-1:0] v);
    logic [7:0] r = 8'h00;
    for (int s = 0; s < SHARES; s++) r ^= v[s*8 +: 8];
    return r;
  endfunction

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Ideal masked S-box with LAT cycles of latency; the result is re-masked with Z
  logic [DW-1:0] sbox_pipe [LAT];
  always @(posedge clk) begin
    sbox_pipe[0] <= {sbox_z[7:0], aes_sbox(xor_shares(sbox_x)) ^ sbox_z[7:0]};
    for (int i = 1; i < LAT; i++) sbox_pipe[i] <= sbox_pipe[i-1];
  end
  assign sbox_q = sbox_pipe[LAT-1];

  // Reference model state
  typedef struct { int idx; logic [7:0] val; int rdy; } item_t;
  item_t mq[$];
  int m_state, m_ptr, cyc, n_issue, n_pop;
  int checks = 0, failures = 0;
  logic exp_issue, exp_out_valid, exp_pop, exp_done;
  int exp_grant;
  logic [NREQ-1:0] exp_req_ready;
  logic [DW-1:0] exp_sx;
  logic [RZW-1:0] exp_sz;
  logic [RBW-1:0] exp_sb;

  task automatic randomize_data();
    req_data = {$urandom, $urandom};
    rnd_z = 8'($urandom);
    rnd_b = {8'($urandom), $urandom};
  endtask

  // Derive this cycle's expected outputs from the model; sampled mid-cycle
  task automatic settle();
    int sz;
    @(negedge clk);
    sz = mq.size();
    exp_out_valid = (sz > 0) && (mq[0].rdy <= cyc);
    exp_pop = exp_out_valid && out_ready;
    exp_grant = -1;
    for (int k = 0; k < NREQ; k++)
      if (exp_grant < 0 && req_valid[(m_ptr + k) % NREQ]) exp_grant = (m_ptr + k) % NREQ;
    exp_issue = !rst && m_state == M_RUN && !flush && rnd_valid && exp_grant >= 0 &&
                (sz - (exp_pop ? 1 : 0) < FDEPTH);
    exp_req_ready = '0;
    if (exp_issue) exp_req_ready[exp_grant] = 1'b1;
  endtask

  // Commit this cycle's events to the model and move to the next cycle
  task automatic advance();
    int sz;
    item_t it;
    sz = mq.size();
    if (rst) begin
      mq.delete(); m_state = M_RUN; m_ptr = 0; exp_done = 1'b0;
      exp_sx = '0; exp_sz = '0; exp_sb = '0;
    end else begin
      exp_done = 1'b0;
      if (exp_pop) begin void'(mq.pop_front()); n_pop++; end
      if (exp_issue) begin
        it.idx = exp_grant;
        it.val = aes_sbox(xor_shares(req_data[exp_grant*DW +: DW]));
        it.rdy = cyc + LAT + 2;
        mq.push_back(it);
        m_ptr = (exp_grant + 1) % NREQ;
        exp_sx = req_data[exp_grant*DW +: DW]; exp_sz = rnd_z; exp_sb = rnd_b;
        n_issue++;
      end else begin
`ifdef SBOX_IDLE_ZERO_EN
        exp_sx = '0; exp_sz = '0; exp_sb = '0;
`endif
      end
      case (m_state)
        M_RUN:   if (flush) m_state = M_DRAIN;
        M_DRAIN: if (sz == 0) begin m_state = M_DONE; exp_done = 1'b1; end
        M_DONE:  if (!flush) m_state = M_RUN;
        default: m_state = M_RUN;
      endcase
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    repeat (2) begin settle(); advance(); end
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    req_valid = '0; out_ready = 1'b1; flush = 1'b0;
    repeat (n) begin settle(); advance(); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; rnd_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    randomize_data();
    repeat (3) begin
      settle();
      checks++;
      if (req_ready !== '0 || rnd_ready !== 1'b0) begin
        failures++; $display("FAIL reset_ready got=%b/%b exp=0000/0", req_ready, rnd_ready);
      end
      advance();
    end
    rst = 1'b0; req_valid = '0;
    settle();
    checks++;
    if (out_valid !== 1'b0 || flush_done !== 1'b0) begin
      failures++; $display("FAIL reset_out got valid=%b done=%b exp=0/0", out_valid, flush_done);
    end
    checks++;
    if (sbox_x !== '0 || sbox_z !== '0 || sbox_b !== '0) begin
      failures++; $display("FAIL reset_sbox got x=%h z=%h b=%h exp=0", sbox_x, sbox_z, sbox_b);
    end
    advance();
  endtask

  task automatic test_single();
    int t0;
    int seen;
    do_reset();
    req_valid = 4'b0001; rnd_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    randomize_data(); req_data[15:0] = 16'h5300;
    settle();
    checks++;
    if (req_ready !== 4'b0001 || rnd_ready !== 1'b1) begin
      failures++; $display("FAIL single_issue got=%b/%b exp=0001/1", req_ready, rnd_ready);
    end
    t0 = cyc; advance();
    req_valid = '0; seen = 0;
    for (int i = 0; i < LAT + 6 && seen == 0; i++) begin
      settle();
      if (i == 0) begin
        checks++;
        if (sbox_x !== 16'h5300) begin
          failures++; $display("FAIL single_sbox_x got=%h exp=5300", sbox_x);
        end
      end
      checks++;
      if (out_valid !== exp_out_valid) begin
        failures++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_out_valid);
      end
      if (out_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (cyc - t0 != LAT + 2) begin
          failures++; $display("FAIL single_latency got=%0d exp=%0d", cyc - t0, LAT + 2);
        end
        checks++;
        if (out_idx !== 2'd0 || xor_shares(out_q) !== 8'hED) begin
          failures++; $display("FAIL single_result got idx=%0d q=%h exp idx=0 q=ed", out_idx, xor_shares(out_q));
        end
      end
      advance();
    end
    checks++;
    if (seen == 0) begin failures++; $display("FAIL single_timeout got=none exp=OutValid"); end
    $display("single: issue cyc=%0d result seen=%0d", t0, seen);
  endtask

  task automatic test_round_robin();
    int g, pops;
    do_reset();
    req_valid = '1; rnd_valid = 1'b1; out_ready = 1'b1; flush = 1'b0; pops = 0;
    for (int i = 0; i < 8; i++) begin
      randomize_data();
      settle();
      g = oh2idx(req_ready);
      checks++;
      if (g != i % NREQ || req_ready !== exp_req_ready) begin
        failures++; $display("FAIL rr_grant i=%0d got=%0d exp=%0d", i, g, i % NREQ);
      end
      if (out_valid === 1'b1) pops++;
      advance();
    end
    req_valid = '0;
    for (int i = 0; i < LAT + 8; i++) begin
      settle();
      if (out_valid === 1'b1) begin
        checks++;
        if (out_idx !== 2'(pops % NREQ) || xor_shares(out_q) !== mq[0].val) begin
          failures++; $display("FAIL rr_order pop=%0d got idx=%0d q=%h exp idx=%0d q=%h",
                               pops, out_idx, xor_shares(out_q), pops % NREQ, mq[0].val);
        end
        pops++;
      end
      advance();
    end
    checks++;
    if (pops != 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", pops); end
    $display("round_robin: pops=%0d", pops);
  endtask

  task automatic test_backpressure();
    int issues, pops;
    drain(LAT + 4);
    out_ready = 1'b0; rnd_valid = 1'b1; issues = 0; pops = 0;
    for (int i = 0; i < FDEPTH + 8; i++) begin
      req_valid = 4'($urandom_range(1, 15)); randomize_data();
      settle();
      checks++;
      if (req_ready !== exp_req_ready) begin
        failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_req_ready);
      end
      if (rnd_ready === 1'b1) issues++;
      advance();
    end
    checks++;
    if (issues != FDEPTH) begin failures++; $display("FAIL bp_issue_count got=%0d exp=%0d", issues, FDEPTH); end
    req_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < FDEPTH + 6; i++) begin
      settle();
      if (exp_out_valid) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'(mq[0].idx) || xor_shares(out_q) !== mq[0].val) begin
          failures++; $display("FAIL bp_drain got v=%b idx=%0d q=%h exp v=1 idx=%0d q=%h",
                               out_valid, out_idx, xor_shares(out_q), mq[0].idx, mq[0].val);
        end
      end
      if (out_valid === 1'b1) pops++;
      advance();
    end
    checks++;
    if (pops != FDEPTH) begin failures++; $display("FAIL bp_pop_count got=%0d exp=%0d", pops, FDEPTH); end
    $display("backpressure: issues=%0d pops=%0d", issues, pops);
  endtask

  task automatic test_rnd_stall();
    out_ready = 1'b1; rnd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'($urandom_range(1, 15)); randomize_data();
      settle();
      checks++;
      if (req_ready !== '0 || rnd_ready !== 1'b0) begin
        failures++; $display("FAIL rnd_stall got=%b/%b exp=0000/0", req_ready, rnd_ready);
      end
      advance();
    end
    rnd_valid = 1'b1;
    settle();
    checks++;
    if (rnd_ready !== 1'b1 || req_ready !== exp_req_ready) begin
      failures++; $display("FAIL rnd_resume got=%b/%b exp=%b/1", req_ready, rnd_ready, exp_req_ready);
    end
    advance();
    drain(LAT + 4);
    $display("rnd_stall: resumed issue checked");
  endtask

  task automatic test_flush();
    int pops, pulses;
    out_ready = 1'b1; rnd_valid = 1'b1; req_valid = 4'b0001; pops = 0; pulses = 0;
    repeat (3) begin
      randomize_data(); settle();
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL flush_pre_issue got=%b exp=0001", req_ready); end
      advance();
    end
    flush = 1'b1; req_valid = '1;
    for (int i = 0; i < 25; i++) begin
      randomize_data(); settle();
      checks++;
      if (req_ready !== '0 || flush_done !== exp_done) begin
        failures++; $display("FAIL flush_phase cyc=%0d got rdy=%b done=%b exp rdy=0000 done=%b",
                             cyc, req_ready, flush_done, exp_done);
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_idx !== 2'd0 || xor_shares(out_q) !== mq[0].val) begin
          failures++; $display("FAIL flush_result got idx=%0d q=%h exp idx=0 q=%h", out_idx, xor_shares(out_q), mq[0].val);
        end
        pops++;
      end
      if (flush_done === 1'b1) pulses++;
      advance();
    end
    checks++;
    if (pops != 3 || pulses != 1) begin
      failures++; $display("FAIL flush_counts got pops=%0d pulses=%0d exp pops=3 pulses=1", pops, pulses);
    end
    flush = 1'b0;
    settle();
    checks++;
    if (req_ready !== exp_req_ready) begin failures++; $display("FAIL flush_exit got=%b exp=%b", req_ready, exp_req_ready); end
    advance();
    settle();
    checks++;
    if (rnd_ready !== 1'b1 || req_ready !== exp_req_ready) begin
      failures++; $display("FAIL flush_resume got=%b/%b exp=%b/1", req_ready, rnd_ready, exp_req_ready);
    end
    advance();
    drain(LAT + 8);
    $display("flush: pops=%0d pulses=%0d", pops, pulses);
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1; rnd_valid = 1'b1; flush = 1'b0; req_valid = 4'b0100;
    randomize_data();
    settle();
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL rstmid_issue got=%b exp=0100", req_ready); end
    advance();
    req_valid = '0;
    settle(); advance();
    rst = 1'b1;
    settle(); advance();
    rst = 1'b0;
    for (int i = 0; i < LAT + 6; i++) begin
      settle();
      checks++;
      if (out_valid !== 1'b0 || sbox_x !== exp_sx) begin
        failures++; $display("FAIL rstmid_out cyc=%0d got v=%b x=%h exp v=0 x=%h", cyc, out_valid, sbox_x, exp_sx);
      end
      advance();
    end
    $display("reset_midflight: no result after reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      rnd_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 40) == 0) flush = ~flush;
      randomize_data();
      settle();
      checks++;
      if (req_ready !== exp_req_ready || rnd_ready !== exp_issue) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b/%b exp=%b/%b", cyc, req_ready, rnd_ready, exp_req_ready, exp_issue);
      end
      checks++;
      if (out_valid !== exp_out_valid || flush_done !== exp_done) begin
        failures++; $display("FAIL rand_status cyc=%0d got v=%b d=%b exp v=%b d=%b", cyc, out_valid, flush_done, exp_out_valid, exp_done);
      end
      checks++;
      if (sbox_x !== exp_sx || sbox_z !== exp_sz || sbox_b !== exp_sb) begin
        failures++; $display("FAIL rand_sbox cyc=%0d got x=%h z=%h b=%h exp x=%h z=%h b=%h",
                             cyc, sbox_x, sbox_z, sbox_b, exp_sx, exp_sz, exp_sb);
      end
      if (exp_out_valid) begin
        checks++;
        if (out_idx !== 2'(mq[0].idx) || xor_shares(out_q) !== mq[0].val) begin
          failures++; $display("FAIL rand_result cyc=%0d got idx=%0d q=%h exp idx=%0d q=%h",
                               cyc, out_idx, xor_shares(out_q), mq[0].idx, mq[0].val);
        end
      end
      advance();
    end
    drain(FDEPTH + LAT + 8);
    $display("random: issues=%0d pops=%0d", n_issue, n_pop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = '0; rnd_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    req_data = '0; rnd_z = '0; rnd_b = '0;
    m_state = M_RUN; m_ptr = 0; cyc = 0; n_issue = 0; n_pop = 0;
    exp_done = 1'b0; exp_sx = '0; exp_sz = '0; exp_sb = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_rnd_stall();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
